// File: rtl/noc_pkg.sv
// Shared constants, types and packet helpers for the node merge scheduler.
package noc_pkg;

    localparam int PKT_W  = 11;
    localparam int ADDR_W = 4;
    localparam int HAM_W  = 7;

    typedef enum logic [1:0] {
        SRC_LANE1 = 2'd0,
        SRC_LANE2 = 2'd1,
        SRC_CORE  = 2'd2
    } src_id_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    function automatic logic [ADDR_W-1:0] pkt_addr(input logic [PKT_W-1:0] p);
        return p[PKT_W-1:HAM_W];
    endfunction

    function automatic logic [HAM_W-1:0] pkt_ham(input logic [PKT_W-1:0] p);
        return p[HAM_W-1:0];
    endfunction

endpackage

// File: rtl/node_merge_sched_rr_pick3.sv
// Combinational three-way round-robin picker.
// Search starts at the source after the last winner.
module rr_pick3
    import noc_pkg::*;
(
    input  logic [2:0] req,
    input  src_id_t    last,
    output logic [2:0] grant
);

    logic [2:0] w_rot;
    logic [2:0] w_pick;

    // Rotate so bit 0 is the highest-priority source.
    always_comb begin
        w_rot = req;
        unique case (last)
            SRC_LANE1: w_rot = {req[0], req[2], req[1]};
            SRC_LANE2: w_rot = {req[1], req[0], req[2]};
            default:   w_rot = req;
        endcase
    end

    always_comb begin
        w_pick = 3'b000;
        if (w_rot[0])
            w_pick = 3'b001;
        else if (w_rot[1])
            w_pick = 3'b010;
        else if (w_rot[2])
            w_pick = 3'b100;
    end

    always_comb begin
        grant = w_pick;
        unique case (last)
            SRC_LANE1: grant = {w_pick[1], w_pick[0], w_pick[2]};
            SRC_LANE2: grant = {w_pick[0], w_pick[2], w_pick[1]};
            default:   grant = w_pick;
        endcase
    end

endmodule

// File: rtl/node_merge_sched.sv
// Round-robin merge of lane1, lane2 and core packets into a
// one-entry output stage feeding path computation.
module node_merge_sched
    import noc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PKT_W-1:0]    in_data [0:2],
    input  logic [2:0]          in_valid,
    output logic [2:0]          in_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [HAM_W-1:0]    out_ham,
    output logic [1:0]          out_src,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    pkt_count
);

    stage_t              r_state;
    stage_t              w_state_nxt;
    src_id_t             r_last;
    src_id_t             r_src;
    src_id_t             w_win;
    logic [ADDR_W-1:0]   r_addr;
    logic [HAM_W-1:0]    r_ham;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          w_grant;
    logic [PKT_W-1:0]    w_data;
    logic                w_space;
    logic                w_fire;

    rr_pick3 u_pick (
        .req   (in_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_space  = (r_state == ST_EMPTY) | out_ready;
    assign in_ready = (reset || !w_space) ? 3'b000 : w_grant;
    assign w_fire   = |in_ready;

    always_comb begin
        w_win  = SRC_LANE1;
        w_data = in_data[0];
        if (w_grant[1]) begin
            w_win  = SRC_LANE2;
            w_data = in_data[1];
        end else if (w_grant[2]) begin
            w_win  = SRC_CORE;
            w_data = in_data[2];
        end
    end

    // A fill wins over a drain so a same-cycle swap stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        if (w_fire)
            w_state_nxt = ST_FULL;
        else if (out_ready)
            w_state_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_ham  <= '0;
            r_src  <= SRC_LANE1;
            r_last <= SRC_CORE;
            r_cnt  <= '0;
        end else if (w_fire) begin
            r_addr <= pkt_addr(w_data);
            r_ham  <= pkt_ham(w_data);
            r_src  <= w_win;
            r_last <= w_win;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_addr  = r_addr;
    assign out_ham   = r_ham;
    assign out_src   = r_src;
    assign pkt_count = r_cnt;

endmodule

// File: tb/tb_node_merge_sched.sv
// Directed self-checking bench for node_merge_sched (CNT_W=4 build).
module tb_node_merge_sched;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [10:0]   in_data [0:2];
    logic [2:0]    in_valid;
    logic [2:0]    in_ready;
    logic [3:0]    out_addr;
    logic [6:0]    out_ham;
    logic [1:0]    out_src;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] pkt_count;

    int errors = 0;
    int checks = 0;

    logic [10:0] d0 = 11'h0A5;
    logic [10:0] d1 = 11'h3C7;
    logic [10:0] d2 = 11'h5A3;

    node_merge_sched #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_addr  (out_addr),
        .out_ham   (out_ham),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 3'b111;
        out_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            errors++;
            $display("FAIL rst_ready got=%b want=000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== 4'd0 ||
            out_addr !== 4'd0 || out_ham !== 7'd0 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL rst_vals got v=%b c=%0d a=%h h=%h s=%0d want all 0",
                     out_valid, pkt_count, out_addr, out_ham, out_src);
        end
        reset = 1'b0;
        in_valid = 3'b000;
    endtask

    task automatic test_single();
        in_valid = 3'b100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            errors++;
            $display("FAIL single_ready got=%b want=100", in_ready);
        end
        tick();
        in_valid = 3'b000;
        checks++;
        if (out_addr !== 4'hB || out_ham !== 7'h23 || out_src !== 2'd2 ||
            out_valid !== 1'b1 || pkt_count !== 4'd1) begin
            errors++;
            $display("FAIL single_out got a=%h h=%h s=%0d v=%b c=%0d want a=b h=23 s=2 v=1 c=1",
                     out_addr, out_ham, out_src, out_valid, pkt_count);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        in_valid = 3'b111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_src !== exp[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_%0d got s=%0d v=%b want s=%0d v=1",
                         i, out_src, out_valid, exp[i]);
            end
        end
        in_valid = 3'b000;
        checks++;
        if (pkt_count !== 4'd7) begin
            errors++;
            $display("FAIL rr_count got=%0d want=7", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 3'b010;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_src !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill got s=%0d v=%b want s=1 v=1", out_src, out_valid);
        end
        in_valid = 3'b101;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 3'b000) begin
                errors++;
                $display("FAIL bp_ready_%0d got=%b want=000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd1 ||
                out_addr !== d1[10:7] || out_ham !== d1[6:0] || pkt_count !== 4'd8) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%b s=%0d a=%h h=%h c=%0d want v=1 s=1 a=%h h=%h c=8",
                         i, out_valid, out_src, out_addr, out_ham, pkt_count,
                         d1[10:7], d1[6:0]);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            errors++;
            $display("FAIL bp_release got=%b want=100", in_ready);
        end
        tick();
        in_valid = 3'b000;
        checks++;
        if (out_src !== 2'd2 || out_addr !== d2[10:7] || pkt_count !== 4'd9) begin
            errors++;
            $display("FAIL bp_after got s=%0d a=%h c=%0d want s=2 a=%h c=9",
                     out_src, out_addr, pkt_count, d2[10:7]);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 3'b001;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b001 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got r=%b v=%b want r=001 v=1", in_ready, out_valid);
        end
        tick();
        in_valid = 3'b000;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 ||
            out_addr !== d0[10:7] || out_ham !== d0[6:0] || pkt_count !== 4'd10) begin
            errors++;
            $display("FAIL b2b_out got v=%b s=%0d a=%h h=%h c=%0d want v=1 s=0 a=%h h=%h c=10",
                     out_valid, out_src, out_addr, out_ham, pkt_count, d0[10:7], d0[6:0]);
        end
    endtask

    task automatic test_wrap();
        in_valid = 3'b010;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pkt_count !== 4'd15) begin
            errors++;
            $display("FAIL wrap_pre got=%0d want=15", pkt_count);
        end
        tick();
        in_valid = 3'b000;
        checks++;
        if (pkt_count !== 4'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap got c=%0d v=%b want c=0 v=1", pkt_count, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_src !== 2'd1 || out_addr !== d1[10:7]) begin
            errors++;
            $display("FAIL drain got v=%b s=%0d a=%h want v=0 s=1 a=%h",
                     out_valid, out_src, out_addr, d1[10:7]);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 3'b001;
        out_ready = 1'b0;
        tick();
        in_valid = 3'b111;
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_ready got r=%b v=%b want r=000 v=1", in_ready, out_valid);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_rst_vals got v=%b c=%0d want v=0 c=0", out_valid, pkt_count);
        end
        #1;
        checks++;
        if (in_ready !== 3'b001) begin
            errors++;
            $display("FAIL mid_rst_grant got=%b want=001", in_ready);
        end
        tick();
        in_valid = 3'b000;
        checks++;
        if (out_src !== 2'd0 || out_valid !== 1'b1 || pkt_count !== 4'd1) begin
            errors++;
            $display("FAIL mid_rst_after got s=%0d v=%b c=%0d want s=0 v=1 c=1",
                     out_src, out_valid, pkt_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 3'b000;
        out_ready = 1'b0;
        in_data[0] = d0;
        in_data[1] = d1;
        in_data[2] = d2;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
